serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial N-bit subtractor computing `a - b - bin` LSB-first, one bit per clock, through a single full-subtractor cell that holds borrow state between cycles. It is the subtract-direction counterpart of the team's full-adder arithmetic cell. It is intended for area-constrained datapaths where a ripple array is too large. Operands are taken in over a valid/ready request handshake, and the result is returned over a valid/ready response handshake.

## Interface
- `WIDTH`, default 8: operand and result width in bits; must be ≥ 2.
- `clk  input  1`: single clock; all state updates on the rising edge.
- `rst_n  input  1`: reset, asynchronous, active-low.
- `req_valid  input  1`: operands present.
- `req_ready  output  1`: block can accept operands.
- `a  input  WIDTH`: minuend.
- `b  input  WIDTH`: subtrahend.
- `bin  input  1`: borrow in.
- `rsp_valid  output  1`: result present.
- `rsp_ready  input  1`: consumer accepts result.
- `diff  output  WIDTH`: `(a - b - bin) mod 2^WIDTH`.
- `bout  output  1`: borrow out; 1 iff `a < b + bin` (unsigned).
- `ovf  output  1`: signed overflow; present only with `SERIAL_SUB_OVF_EN`.

## Operation
- Three-state FSM:
  - IDLE: `req_ready=1`. On `req_valid`, latch `a`, `b` and `bin` into shift registers and the borrow flop, clear the bit counter, and go to RUN.
  - RUN: each cycle, feed `a_sr[0]`, `b_sr[0]` and `borrow` to the cell.
    - `d = a ^ b ^ bi`
    - `bo = (~a & b) | (~(a ^ b) & bi)`
    - Shift `d` into `diff_sr` from the MSB end, shift the operand registers right, store `bo` in `borrow`, and increment the counter.
    - After the WIDTH-th bit, go to DONE.
  - DONE: `rsp_valid=1`, with `diff`, `bout` (and `ovf`) stable. On `rsp_ready`, go to IDLE.
- Outputs are registered. `diff` and `bout` hold the last result until the next result is written. They are not cleared on leaving DONE.
- `req_ready` is 0 in RUN and DONE. New requests stall; there is no queuing.
- Counter width is `$clog2(WIDTH+1)`. Terminal count is `WIDTH-1` on the last RUN cycle.
- Reset values: FSM IDLE, `req_ready=1`, `rsp_valid=0`, `diff=0`, `bout=0`, `ovf=0`, all internal registers 0.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately. No partial result is presented.
- Operands changing while `req_ready=0` have no effect.

## Timing
- Request accepted on edge E0 (`req_valid & req_ready`).
- RUN spans edges E1..E_WIDTH.
- `rsp_valid` is high after edge E_WIDTH, so latency is WIDTH+1 cycles from acceptance to the response being visible.
- Response completes on the first edge with `rsp_valid & rsp_ready`. `req_ready` is high the following cycle.
- Minimum initiation interval: WIDTH+2 cycles (accept, WIDTH bits, one DONE cycle with `rsp_ready` tied high).
- `rsp_valid`, once asserted, stays asserted with stable data until accepted.
- `req_ready` does not depend combinationally on `req_valid`. `rsp_valid` does not depend on `rsp_ready`.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - Port `ovf` exists.
  - It is set in DONE to `(a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])`, using the latched sign bits of `a` and `b`.
  - It is registered with `diff`.
- `SERIAL_SUB_OVF_EN` not defined:
  - Port `ovf` and its sign-capture flops are absent.
  - All other behaviour is identical.

## Structure
- Shared package `arith_pkg`:
  - FSM state enum `sub_state_t` (IDLE, RUN, DONE).
  - Default width constant `ARITH_DEFAULT_WIDTH = 8`.
- Sub-module `full_subtractor`:
  - Combinational, ports `d`, `bo`, `a`, `b`, `bi`.
  - One instance, which is the per-bit cell.

## Test plan
All scenarios use WIDTH=8.
- Basic: `a=0x05`, `b=0x03`, `bin=0` → `diff=0x02`, `bout=0`, `ovf=0`. `rsp_valid` is high on the 9th cycle after acceptance.
- Borrow: `a=0x03`, `b=0x05`, `bin=0` → `diff=0xFE`, `bout=1`, `ovf=0`.
- Borrow-in wrap: `a=0x00`, `b=0x00`, `bin=1` → `diff=0xFF`, `bout=1`. With `a=0xFF`, `b=0xFF`, `bin=0` → `diff=0x00`, `bout=0`.
- Signed overflow (macro on): `a=0x80`, `b=0x01` → `diff=0x7F`, `bout=0`, `ovf=1`. With `a=0x7F`, `b=0xFF` → `diff=0x80`, `bout=1`, `ovf=1`.
- Handshake:
  - Hold `rsp_ready=0` for 5 cycles → `rsp_valid` and `diff` stay stable, and `req_ready` stays 0 while `req_valid` is held high.
  - Release `rsp_ready` → `req_ready` is 1 next cycle.
  - Next request is accepted, and 0xAA−0x55 → `diff=0x55`.
- Reset mid-op: assert `rst_n=0` at bit 4 of RUN → `rsp_valid=0`, `diff=0`, `req_ready=1` immediately. After release, a fresh 0x10−0x01 yields `diff=0x0F`.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: serial FSM state encoding and default datapath width.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int unsigned ARITH_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = a - b - bi, bo is the borrow out of this bit.
module full_subtractor (
  output logic d,
  output logic bo,
  input  logic a,
  input  logic b,
  input  logic bi
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, through one full_subtractor cell.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = ARITH_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Only WIDTH-1 partial bits need storing; the final bit comes straight from the cell.
  logic [WIDTH-2:0] diff_sr;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] diff_next;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  full_subtractor u_cell (
    .d  (cell_d),
    .bo (cell_bo),
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .bi (borrow)
  );

  always_comb begin
    diff_next = {cell_d, diff_sr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      diff_sr   <= '0;
      borrow    <= 1'b0;
      cnt       <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf       <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_sr      <= a;
            b_sr      <= b;
            borrow    <= bin;
            diff_sr   <= '0;
            cnt       <= '0;
            req_ready <= 1'b0;
            state     <= RUN;
`ifdef SERIAL_SUB_OVF_EN
            a_msb     <= a[WIDTH-1];
            b_msb     <= b[WIDTH-1];
`endif
          end
        end

        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          borrow  <= cell_bo;
          diff_sr <= diff_next[WIDTH-1:1];
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            diff      <= diff_next;
            bout      <= cell_bo;
            rsp_valid <= 1'b1;
            state     <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            ovf       <= (a_msb != b_msb) && (diff_next[WIDTH-1] != a_msb);
`endif
          end
        end

        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
